// File: rtl/spm_serial_driver_if.sv
// Operand/product handshake bundle between a client and the serial-parallel multiplier driver.
// The client drives operands and out_ready; the driver answers with in_ready and the product.
interface spm_serial_driver_if #(
  parameter int unsigned WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_x;
  logic [WIDTH-1:0]   in_y;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/spm_serial_driver.sv
// Sequencer for a serial-parallel multiplier array: holds x in parallel, feeds sign-extended
// y LSB first, and collects the serial product back into a parallel word.
module spm_serial_driver #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  spm_serial_driver_if.slave     bus,
  output logic                   busy,
  output logic [WIDTH-1:0]       spm_x,
  output logic                   spm_y,
  input  logic                   spm_p,
  output logic                   spm_rst
);

  localparam int unsigned NCyc = 2 * WIDTH + LAT;
  localparam int unsigned CntW = $clog2(NCyc);
  localparam logic [CntW-1:0] CntLast = CntW'(NCyc - 1);

  typedef enum logic [1:0] {StIdle, StClear, StShift, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 accept;
  logic                 sample_en;
  logic                 y_live;

  assign accept = (state_q == StIdle) && bus.in_valid;

  // With LAT=0 every shift cycle samples and carries a live y bit; the compares would be constant.
  if (LAT == 0) begin : g_lat0
    assign sample_en = 1'b1;
    assign y_live    = 1'b1;
  end else begin : g_lat
    localparam logic [CntW-1:0] CntLat  = CntW'(LAT);
    localparam logic [CntW-1:0] CntSext = CntW'(2 * WIDTH);
    assign sample_en = (cnt_q >= CntLat);
    assign y_live    = (cnt_q < CntSext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StClear;
      StClear: state_d = StShift;
      StShift: if (cnt_q == CntLast) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      p_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      x_q   <= x_d;
      y_q   <= y_d;
      p_q   <= p_d;
    end
  end

  // y is consumed by an arithmetic right shift, so bit 0 walks through y and then repeats the sign.
  always_comb begin
    cnt_d = cnt_q;
    x_d   = x_q;
    y_d   = y_q;
    p_d   = p_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          x_d = bus.in_x;
          y_d = bus.in_y;
        end
      end
      StClear: cnt_d = '0;
      StShift: begin
        if (cnt_q != CntLast) cnt_d = cnt_q + 1'b1;
        y_d = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
        if (sample_en) p_d = {spm_p, p_q[2*WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  // Outputs are forced to their idle values while rst is high, ahead of the reset edge.
  always_comb begin
    bus.in_ready  = !rst && (state_q == StIdle);
    bus.out_valid = !rst && (state_q == StDone);
    bus.out_p     = rst ? '0 : p_q;
    busy          = !rst && (state_q != StIdle);
    spm_x         = rst ? '0 : x_q;
    spm_y         = !rst && (state_q == StShift) && y_live && y_q[0];
    spm_rst       = rst || (state_q != StShift);
  end

endmodule

// File: doc/spm_serial_driver.md
SPM_SERIAL_DRIVER -- requirements
Module: spm_serial_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; legal range 2..64.
REQ-002 SHALL have parameter LAT, default 1: cycles from a spm_y bit to its matching spm_p bit; legal range 0..3.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: operand pair offered.
REQ-006 SHALL have port in_ready, output, 1: driver can accept an operand pair.
REQ-007 SHALL have port in_x, input, WIDTH: parallel multiplicand, two's complement.
REQ-008 SHALL have port in_y, input, WIDTH: multiplier to serialize, two's complement.
REQ-009 SHALL have port out_valid, output, 1: product available.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the product.
REQ-011 SHALL have port out_p, output, 2*WIDTH: signed product.
REQ-012 SHALL have port busy, output, 1: an operation is in progress (state not IDLE).
REQ-013 SHALL have port spm_x, output, WIDTH: parallel operand driven to the multiplier array.
REQ-014 SHALL have port spm_y, output, 1: serial multiplier bit, LSB first.
REQ-015 SHALL have port spm_p, input, 1: serial product bit from the array, LSB first.
REQ-016 SHALL have port spm_rst, output, 1: clear for the multiplier array's carry-save registers.

Function
REQ-017 SHALL implement the states IDLE, CLEAR, SHIFT and DONE with the following transitions.
- IDLE to CLEAR on in_valid && in_ready.
- CLEAR to SHIFT after exactly 1 cycle.
- SHIFT to DONE when the cycle counter reaches 2*WIDTH+LAT-1.
- DONE to IDLE on out_ready.
REQ-018 SHALL assert in_ready only in IDLE; in_valid outside IDLE SHALL be ignored and no operand SHALL be latched.
REQ-019 SHALL latch in_x and in_y on acceptance; spm_x SHALL hold the latched x from CLEAR through DONE.
REQ-020 SHALL drive spm_rst=1 in IDLE, CLEAR and DONE, and spm_rst=0 only in SHIFT.
REQ-021 SHALL, in SHIFT cycle c (c=0..2*WIDTH+LAT-1), drive spm_y as follows.
- c<WIDTH: y[c].
- WIDTH<=c<2*WIDTH: y[WIDTH-1] (sign extension).
- c>=2*WIDTH: 0.
REQ-022 SHALL drive spm_y=0 outside SHIFT.
REQ-023 SHALL sample spm_p in SHIFT cycles c>=LAT; the sample taken in cycle c SHALL be product bit c-LAT.
REQ-024 SHALL build out_p by right-shift insertion at the MSB, so that after 2*WIDTH samples bit k holds product bit k.
REQ-025 SHALL hold out_p stable while out_valid=1.
REQ-026 SHALL assert out_valid only in DONE; out_valid and out_p SHALL hold until out_ready=1.
REQ-027 SHALL return to IDLE on the out_valid && out_ready cycle, with in_ready=1 on the next cycle.
REQ-028 SHALL give a latency from the acceptance edge to the first out_valid=1 cycle of 2*WIDTH+LAT+2 cycles.
REQ-029 SHALL give a throughput of one operation per 2*WIDTH+LAT+3 cycles when out_ready=1 and in_valid=1 are held.
REQ-030 SHALL use a cycle counter of width clog2(2*WIDTH+LAT) and SHALL NOT wrap within an operation.
REQ-031 SHALL produce out_p as the 2*WIDTH-bit two's-complement product x*y, including the most-negative-operand cases.

Reset
REQ-032 SHALL, with rst=1 at a clock edge, enter IDLE and clear the counter, out_p and the latched operands.
REQ-033 SHALL drive the following outputs while rst=1 and on the cycle after it.
- in_ready=0 during rst=1 and 1 on the cycle after.
- out_valid=0, out_p=0, busy=0, spm_x=0, spm_y=0.
- spm_rst=1.
REQ-034 SHALL, on rst asserted mid-operation (CLEAR, SHIFT or DONE), abandon the operation and produce no out_valid for it.
REQ-035 SHALL give rst priority over a simultaneous in_valid or out_ready.

Verification
REQ-036 SHALL be verified (WIDTH=8, LAT=1, driver connected to a behavioural spm model) with these directed scenarios.
- x=3, y=5, out_ready=1: out_p=0x000F; out_valid first high 19 cycles after acceptance.
- x=-1 (0xFF), y=-1 (0xFF): out_p=0x0001; the spm_y trace shows eight 1s, then eight 1s, then one 0.
- x=-128 (0x80), y=127 (0x7F): out_p=0xC080; then x=-128, y=-128: out_p=0x4000.
- out_ready held 0 for 10 cycles after out_valid: out_p stable, in_ready=0, and a second in_valid during the hold is not accepted.
- rst pulsed in SHIFT cycle 5: next cycle in_ready=1, out_valid=0, spm_rst=1; the next operation x=2, y=3 yields 0x0006.
- Back-to-back x=7,y=9 then x=-3,y=4 with in_valid and out_ready held 1: results 0x003F then 0xFFF4, acceptances 20 cycles apart.
